// File: rtl/matrix_3x3_gen_if.sv
// matrix_3x3_gen_if: pixel stream in, 3x3 window stream out
interface matrix_3x3_gen_if #(parameter int DATA_WIDTH = 8);
  logic                  pre_img_vsync;
  logic                  pre_img_hsync;
  logic                  pre_img_valid;
  logic [DATA_WIDTH-1:0] pre_img_data;
  logic                  matrix_img_vsync;
  logic                  matrix_img_hsync;
  logic                  matrix_img_valid;
  logic [DATA_WIDTH-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DATA_WIDTH-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DATA_WIDTH-1:0] matrix_p31, matrix_p32, matrix_p33;
  modport master (
    output pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
    input  matrix_img_vsync, matrix_img_hsync, matrix_img_valid,
    input  matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33
  );
  modport slave (
    input  pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
    output matrix_img_vsync, matrix_img_hsync, matrix_img_valid,
    output matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33
  );
endinterface

// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen: two line buffers plus column taps forming a zero-padded 3x3 window
module matrix_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int H_DISP     = 800,
  parameter int V_DISP     = 600
) (
  input logic clk,
  input logic rst_n,
  matrix_3x3_gen_if.slave bus
);
  localparam int COL_W = H_DISP > 1 ? $clog2(H_DISP) : 1;
  localparam int ROW_W = V_DISP > 1 ? $clog2(V_DISP) : 1;
  typedef logic [DATA_WIDTH-1:0] pix_t;
  pix_t lb1 [H_DISP];
  pix_t lb2 [H_DISP];
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [1:0] vs_d, hs_d, vld_d;
  pix_t r1_q, r2_q, cur_q;
  logic c0_q, c1_q;
  pix_t win [3][3];
  pix_t new_col [3];
  logic vs_rise, vld_fall;
  assign vs_rise  = bus.pre_img_vsync & ~vs_d[0];
  assign vld_fall = vld_d[0] & ~bus.pre_img_valid;
  assign new_col[0] = r2_q;
  assign new_col[1] = r1_q;
  assign new_col[2] = cur_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (vs_rise) begin
      col <= '0;
      row <= '0;
    end else if (bus.pre_img_valid) begin
      col <= col == COL_W'(H_DISP - 1) ? '0 : col + 1'b1;
    end else if (vld_fall) begin
      col <= '0;
      row <= row == ROW_W'(V_DISP - 1) ? row : row + 1'b1;
    end
  // read-before-write: the old r-1 value cascades into the r-2 buffer
  always_ff @(posedge clk)
    if (bus.pre_img_valid) begin
      lb1[col] <= bus.pre_img_data;
      lb2[col] <= lb1[col];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_d  <= '0;
      hs_d  <= '0;
      vld_d <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      cur_q <= '0;
      c0_q  <= 1'b0;
      c1_q  <= 1'b0;
    end else begin
      vs_d  <= {vs_d[0], bus.pre_img_vsync};
      hs_d  <= {hs_d[0], bus.pre_img_hsync};
      vld_d <= {vld_d[0], bus.pre_img_valid};
      if (bus.pre_img_valid) begin
        r1_q  <= row == '0 ? '0 : lb1[col];
        r2_q  <= row < ROW_W'(2) ? '0 : lb2[col];
        cur_q <= bus.pre_img_data;
        c0_q  <= col == '0;
        c1_q  <= col == COL_W'(1);
      end
    end
  // line start clears the taps that would otherwise hold the previous line's tail
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else if (vld_d[0]) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= (c0_q | c1_q) ? '0 : win[i][1];
        win[i][1] <= c0_q ? '0 : win[i][2];
        win[i][2] <= new_col[i];
      end
    end
  assign bus.matrix_img_vsync = vs_d[1];
  assign bus.matrix_img_hsync = hs_d[1];
  assign bus.matrix_img_valid = vld_d[1];
  assign bus.matrix_p11 = win[0][0];
  assign bus.matrix_p12 = win[0][1];
  assign bus.matrix_p13 = win[0][2];
  assign bus.matrix_p21 = win[1][0];
  assign bus.matrix_p22 = win[1][1];
  assign bus.matrix_p23 = win[1][2];
  assign bus.matrix_p31 = win[2][0];
  assign bus.matrix_p32 = win[2][1];
  assign bus.matrix_p33 = win[2][2];
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// tb_matrix_3x3_gen: directed frames against a zero-padded window model
module tb_matrix_3x3_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int img [6][4];
  logic [71:0] q [$];
  logic [71:0] obs [12];
  int obs_n = 0;
  logic obs_en = 1'b0;
  logic [71:0] last_win = '0;
  logic [2:0] h0 = '0, h1 = '0;
  matrix_3x3_gen_if #(.DATA_WIDTH(8)) bus ();
  matrix_3x3_gen #(.DATA_WIDTH(8), .H_DISP(4), .V_DISP(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [71:0] win_of(input int r, input int c);
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int rr = r - 2 + i;
        int cc = c - 2 + j;
        int v = (rr < 0 || cc < 0) ? 0 : img[rr][cc];
        w = {w[63:0], v[7:0]};
      end
    return w;
  endfunction
  function automatic logic [71:0] dut_win();
    return {bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
            bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
            bus.matrix_p31, bus.matrix_p32, bus.matrix_p33};
  endfunction
  always @(negedge clk) begin
    logic [71:0] w, exp;
    logic [2:0] s;
    w = dut_win();
    s = {bus.matrix_img_vsync, bus.matrix_img_hsync, bus.matrix_img_valid};
    if (!rst_n) begin
      check("reset_zero", {5'b0, s, w}, '0);
      h0 = '0;
      h1 = '0;
      q.delete();
      last_win = '0;
    end else begin
      check("sync_delay", {77'b0, s}, {77'b0, h1});
      if (s[0]) begin
        exp = q.size() > 0 ? q.pop_front() : ~w;
        check("window", {8'b0, w}, {8'b0, exp});
        if (obs_en && obs_n < 12) begin
          obs[obs_n] = w;
          obs_n++;
        end
        last_win = w;
      end else
        check("hold", {8'b0, w}, {8'b0, last_win});
      h1 = h0;
      h0 = {bus.pre_img_vsync, bus.pre_img_hsync, bus.pre_img_valid};
    end
  end
  task automatic drive(input logic vs, input logic hs, input logic v, input int d);
    @(posedge clk);
    #1;
    bus.pre_img_vsync = vs;
    bus.pre_img_hsync = hs;
    bus.pre_img_valid = v;
    bus.pre_img_data  = d[7:0];
  endtask
  task automatic reset_pulse();
    @(posedge clk);
    #1;
    bus.pre_img_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic send_frame(input int base, input int rows, input int rst_row, input int rst_col);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 4; c++)
        img[r][c] = base + 10 * r + c;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r == rst_row && c == rst_col) begin
          reset_pulse();
          return;
        end
        q.push_back(win_of(r, c));
        drive(0, 0, 1, img[r][c]);
      end
      drive(0, 1, 0, 0);
    end
  endtask
  initial begin
    bus.pre_img_vsync = 1'b0;
    bus.pre_img_hsync = 1'b0;
    bus.pre_img_valid = 1'b0;
    bus.pre_img_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    obs_en = 1'b1;
    send_frame(0, 3, -1, -1);
    repeat (3) @(posedge clk);
    obs_en = 1'b0;
    check("win_0_0", {8'b0, obs[0]},  {8'b0, 72'h00_0000_0000_0000_0000});
    check("win_1_1", {8'b0, obs[5]},  {8'b0, 72'h00_0000_0000_0100_0a0b});
    check("win_2_2", {8'b0, obs[10]}, {8'b0, 72'h00_0102_0a0b_0c14_1516});
    send_frame(100, 6, -1, -1);
    send_frame(30, 6, 5, 2);
    send_frame(60, 3, -1, -1);
    send_frame(150, 2, -1, -1);
    send_frame(200, 3, -1, -1);
    repeat (5) @(posedge clk);
    check("drain", {48'b0, 32'(q.size())}, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
